// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory read port (address out, data in) between two
//   requesters. One read in flight at a time, fixed external read latency
//   MEM_LAT (1..15), and each response is steered back to its issuer.
//   Arbitration is round-robin (strict alternation on a tie) by default.
//   Define ARB_FIXED_PRIO_EN to make requester 0 win every tie instead.
module mem_port_arbiter #(
  parameter int AW      = 6,
  parameter int DW      = 6,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          busy,
  output logic          owner
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Counter is loaded with MEM_LAT-1 so MEM_LAT=1 completes on the first WAIT edge.
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t          state_reg;
  state_t          state_next;
  logic [3:0]      lat_cnt_reg;
  logic [AW-1:0]   mem_addr_reg;
  logic            owner_reg;
  logic            last_reg;

  logic [1:0]      req_valid_vec;
  logic [1:0]      ready_vec;
  logic            grant;
  logic            accept;
  logic            done;
  logic [AW-1:0]   grant_addr;

  assign req_valid_vec = {req1_valid, req0_valid};
  assign accept        = (state_reg == S_IDLE) && (req0_valid || req1_valid);
  assign done          = (state_reg == S_WAIT) && (lat_cnt_reg == 4'd0);
  assign grant_addr    = grant ? req1_addr : req0_addr;

  // Winner selection: a lone requester always wins; a tie goes to the one
  // that did not win last time (or to requester 0 in fixed-priority builds).
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_reg;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready is purely combinational and only ever offered while idle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_ready
      assign ready_vec[gi] = (state_reg == S_IDLE) && req_valid_vec[gi] && (grant == 1'(gi));
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: IDLE -> WAIT on accept, WAIT -> IDLE when latency expires.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = S_WAIT;
      S_WAIT: if (lat_cnt_reg == 4'd0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Transaction launch registers and the latency countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_reg <= '0;
      owner_reg    <= 1'b0;
      last_reg     <= 1'b1;
      lat_cnt_reg  <= 4'd0;
    end else if (accept) begin
      mem_addr_reg <= grant_addr;
      owner_reg    <= grant;
      last_reg     <= grant;
      lat_cnt_reg  <= LAT_INIT;
    end else if ((state_reg == S_WAIT) && (lat_cnt_reg != 4'd0)) begin
      lat_cnt_reg  <= lat_cnt_reg - 4'd1;
    end
  end

  // Per-requester response capture: data holds until that requester's next read.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_rsp
      logic          rsp_valid_reg;
      logic [DW-1:0] rsp_data_reg;

      // Capture memory data and pulse valid for the owner of the completing read.
      always_ff @(posedge clk) begin
        if (reset) begin
          rsp_valid_reg <= 1'b0;
          rsp_data_reg  <= '0;
        end else begin
          rsp_valid_reg <= 1'b0;
          if (done && (owner_reg == 1'(gi))) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= mem_data;
          end
        end
      end
    end
  endgenerate

  assign rsp0_valid = gen_rsp[0].rsp_valid_reg;
  assign rsp0_data  = gen_rsp[0].rsp_data_reg;
  assign rsp1_valid = gen_rsp[1].rsp_valid_reg;
  assign rsp1_data  = gen_rsp[1].rsp_data_reg;

  assign mem_addr = mem_addr_reg;
  assign busy     = (state_reg == S_WAIT);
  assign owner    = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3),
// each with a memory model returning addr+10, a response scoreboard and a monitor.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic       id;
    logic [5:0] data;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  rsp_t sb_a[$];
  rsp_t sb_b[$];
  int   acc_a[$];
  int   acc_b[$];

  // Instance A: MEM_LAT = 1
  logic       a_reset, a_req0_valid, a_req1_valid;
  logic [5:0] a_req0_addr, a_req1_addr;
  logic       a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid;
  logic [5:0] a_rsp0_data, a_rsp1_data, a_mem_addr, a_mem_data;
  logic       a_busy, a_owner;

  // Instance B: MEM_LAT = 3
  logic       b_reset, b_req0_valid, b_req1_valid;
  logic [5:0] b_req0_addr, b_req1_addr;
  logic       b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
  logic [5:0] b_rsp0_data, b_rsp1_data, b_mem_addr, b_mem_data;
  logic       b_busy, b_owner;

  assign a_mem_data = a_mem_addr + 6'd10;
  assign b_mem_data = b_mem_addr + 6'd10;

  mem_port_arbiter #(.AW(6), .DW(6), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(a_reset),
    .req0_valid(a_req0_valid), .req0_addr(a_req0_addr), .req0_ready(a_req0_ready),
    .rsp0_valid(a_rsp0_valid), .rsp0_data(a_rsp0_data),
    .req1_valid(a_req1_valid), .req1_addr(a_req1_addr), .req1_ready(a_req1_ready),
    .rsp1_valid(a_rsp1_valid), .rsp1_data(a_rsp1_data),
    .mem_addr(a_mem_addr), .mem_data(a_mem_data), .busy(a_busy), .owner(a_owner)
  );

  mem_port_arbiter #(.AW(6), .DW(6), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(b_reset),
    .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_ready(b_req0_ready),
    .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data),
    .req1_valid(b_req1_valid), .req1_addr(b_req1_addr), .req1_ready(b_req1_ready),
    .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data),
    .mem_addr(b_mem_addr), .mem_data(b_mem_data), .busy(b_busy), .owner(b_owner)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic rsp_t mk(input logic id, input logic [5:0] d);
    rsp_t r;
    r.id   = id;
    r.data = d;
    return r;
  endfunction

  // Monitor A: pops the scoreboard on every response pulse
  always @(negedge clk) begin
    rsp_t e;
    if (!a_reset) begin
      if (a_rsp0_valid) check("a_rsp_exclusive", a_rsp1_valid, 0);
      if (a_rsp0_valid || a_rsp1_valid) begin
        $display("A rsp id=%0d data=%0d cycle=%0d", a_rsp1_valid, a_rsp1_valid ? a_rsp1_data : a_rsp0_data, cyc);
        check("a_rsp_expected", sb_a.size() > 0, 1);
        if (sb_a.size() > 0) begin
          e = sb_a.pop_front();
          check("a_rsp_id", a_rsp1_valid, e.id);
          check("a_rsp_data", a_rsp1_valid ? a_rsp1_data : a_rsp0_data, e.data);
          check("a_rsp_has_accept", acc_a.size() > 0, 1);
          if (acc_a.size() > 0) check("a_rsp_latency", cyc - acc_a.pop_front(), 2);
        end
      end
      if (a_req0_ready || a_req1_ready) begin
        check("a_ready_only_idle", a_busy, 0);
        acc_a.push_back(cyc);
      end
    end
  end

  // Monitor B: same as A, latency 1+3
  always @(negedge clk) begin
    rsp_t e;
    if (!b_reset) begin
      if (b_rsp0_valid) check("b_rsp_exclusive", b_rsp1_valid, 0);
      if (b_rsp0_valid || b_rsp1_valid) begin
        $display("B rsp id=%0d data=%0d cycle=%0d", b_rsp1_valid, b_rsp1_valid ? b_rsp1_data : b_rsp0_data, cyc);
        check("b_rsp_expected", sb_b.size() > 0, 1);
        if (sb_b.size() > 0) begin
          e = sb_b.pop_front();
          check("b_rsp_id", b_rsp1_valid, e.id);
          check("b_rsp_data", b_rsp1_valid ? b_rsp1_data : b_rsp0_data, e.data);
          check("b_rsp_has_accept", acc_b.size() > 0, 1);
          if (acc_b.size() > 0) check("b_rsp_latency", cyc - acc_b.pop_front(), 4);
        end
      end
      if (b_req0_ready || b_req1_ready) begin
        check("b_ready_only_idle", b_busy, 0);
        acc_b.push_back(cyc);
      end
    end
  end

  task automatic drain_a();
    int k = 0;
    while (sb_a.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    check("a_drain_left", sb_a.size(), 0);
  endtask

  task automatic drain_b();
    int k = 0;
    while (sb_b.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    check("b_drain_left", sb_b.size(), 0);
  endtask

  // Wait (bounded) for a negedge where instance A shows a ready.
  task automatic wait_rdy_a(output int g, output int at);
    int k = 0;
    g  = -1;
    at = 0;
    while (k < 20) begin
      @(negedge clk);
      if (a_req0_ready || a_req1_ready) begin
        g  = a_req1_ready ? 1 : 0;
        at = cyc;
        break;
      end
      k++;
    end
    check("a_ready_seen", g >= 0, 1);
  endtask

  task automatic wait_rdy_b(output int g, output int at);
    int k = 0;
    g  = -1;
    at = 0;
    while (k < 20) begin
      @(negedge clk);
      if (b_req0_ready || b_req1_ready) begin
        g  = b_req1_ready ? 1 : 0;
        at = cyc;
        break;
      end
      k++;
    end
    check("b_ready_seen", g >= 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, at, prev;
    int exp_g[4];
    a_reset = 1; a_req0_valid = 0; a_req1_valid = 0; a_req0_addr = 0; a_req1_addr = 0;
    b_reset = 1; b_req0_valid = 0; b_req1_valid = 0; b_req0_addr = 0; b_req1_addr = 0;

    // 1. reset values
    repeat (2) @(posedge clk);
    #1 a_reset = 0; b_reset = 0;
    @(negedge clk);
    check("a_rst_mem_addr", a_mem_addr, 0);
    check("a_rst_busy", a_busy, 0);
    check("a_rst_owner", a_owner, 0);
    check("a_rst_rsp0_valid", a_rsp0_valid, 0);
    check("a_rst_rsp1_valid", a_rsp1_valid, 0);
    check("a_rst_rsp0_data", a_rsp0_data, 0);
    check("a_rst_rsp1_data", a_rsp1_data, 0);
    check("b_rst_mem_addr", b_mem_addr, 0);
    check("b_rst_busy", b_busy, 0);
    check("b_rst_rsp1_data", b_rsp1_data, 0);

    // 2. single read from req0 at addr 5, MEM_LAT=1
    @(posedge clk); #1;
    a_req0_valid = 1; a_req0_addr = 6'd5;
    sb_a.push_back(mk(1'b0, 6'd15));
    $display("A issue req0 addr=5");
    @(negedge clk);
    check("t2_req0_ready", a_req0_ready, 1);
    check("t2_req1_ready", a_req1_ready, 0);
    @(posedge clk); #1 a_req0_valid = 0;
    @(negedge clk);
    check("t2_mem_addr", a_mem_addr, 5);
    check("t2_busy", a_busy, 1);
    check("t2_owner", a_owner, 0);
    check("t2_ready_in_wait", a_req0_ready, 0);
    drain_a();
    check("t2_rsp0_data", a_rsp0_data, 15);
    check("t2_rsp1_untouched", a_rsp1_data, 0);

    // 3. both requesters held valid after a fresh reset
    @(posedge clk); #1 a_reset = 1;
    @(posedge clk); #1 a_reset = 0;
    acc_a.delete();
`ifdef ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    a_req0_valid = 1; a_req0_addr = 6'd3;
    a_req1_valid = 1; a_req1_addr = 6'd9;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_rdy_a(g, at);
      check("t3_grant", g, exp_g[k]);
      if (k > 0) check("t3_grant_spacing", at - prev, 2);
      prev = at;
      sb_a.push_back(mk(exp_g[k] == 1, (exp_g[k] == 1) ? 6'd19 : 6'd13));
      $display("A issue grant%0d expected id=%0d", k, exp_g[k]);
    end
    @(posedge clk); #1 a_req0_valid = 0; a_req1_valid = 0;
    drain_a();
    check("t3_rsp0_data", a_rsp0_data, 13);
`ifdef ARB_FIXED_PRIO_EN
    check("t3_rsp1_data", a_rsp1_data, 0);
`else
    check("t3_rsp1_data", a_rsp1_data, 19);
`endif

    // 4. MEM_LAT=3, req1 at addr 63
    @(posedge clk); #1;
    b_req1_valid = 1; b_req1_addr = 6'd63;
    sb_b.push_back(mk(1'b1, 6'd9));
    $display("B issue req1 addr=63");
    @(negedge clk);
    check("t4_req1_ready", b_req1_ready, 1);
    @(posedge clk); #1 b_req1_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_mem_addr", b_mem_addr, 63);
      check("t4_busy", b_busy, 1);
    end
    @(negedge clk);
    check("t4_busy_end", b_busy, 0);
    check("t4_rsp1_valid", b_rsp1_valid, 1);
    check("t4_rsp1_data", b_rsp1_data, 9);
    drain_b();

    // 5. reset in the second WAIT cycle drops the read
    @(posedge clk); #1;
    b_req0_valid = 1; b_req0_addr = 6'd7;
    $display("B issue req0 addr=7 (to be dropped)");
    @(negedge clk);
    check("t5_req0_ready", b_req0_ready, 1);
    @(posedge clk); #1 b_req0_valid = 0;
    @(posedge clk); #1 b_reset = 1;
    @(posedge clk); #1 b_reset = 0;
    acc_b.delete();
    @(negedge clk);
    check("t5_busy", b_busy, 0);
    check("t5_mem_addr", b_mem_addr, 0);
    check("t5_owner", b_owner, 0);
    check("t5_rsp0_valid", b_rsp0_valid, 0);
    check("t5_rsp0_data", b_rsp0_data, 0);
    repeat (6) @(posedge clk);
    #1;
    b_req0_valid = 1; b_req0_addr = 6'd20;
    b_req1_valid = 1; b_req1_addr = 6'd30;
    @(negedge clk);
    check("t5_first_req0", b_req0_ready, 1);
    check("t5_first_req1", b_req1_ready, 0);
    sb_b.push_back(mk(1'b0, 6'd30));
    $display("B issue req0 addr=20");
    @(posedge clk); #1 b_req0_valid = 0;
    wait_rdy_b(g, at);
    check("t5_second_grant", g, 1);
    sb_b.push_back(mk(1'b1, 6'd40));
    $display("B issue req1 addr=30");
    @(posedge clk); #1 b_req1_valid = 0;
    drain_b();

    // 6. req1 alone, back-to-back addresses 1,2,3
    @(posedge clk); #1;
    a_req1_valid = 1; a_req1_addr = 6'd1;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_rdy_a(g, at);
      check("t6_grant", g, 1);
      if (k > 0) check("t6_accept_spacing", at - prev, 2);
      prev = at;
      sb_a.push_back(mk(1'b1, 6'(11 + k)));
      $display("A issue req1 addr=%0d", k + 1);
      @(posedge clk); #1;
      if (k < 2) a_req1_addr = 6'(k + 2);
      else a_req1_valid = 0;
    end
    drain_a();
    repeat (3) @(negedge clk);
    check("t6_mem_addr_hold", a_mem_addr, 3);
    check("t6_rsp1_data", a_rsp1_data, 13);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
